// File: rtl/tuner_iq_scheduler.sv
// Digital down-converter sequencer: time-shares one external mixer between the
// I (cos) and Q (sin) products of each accepted sample, driven by a phase accumulator.
module tuner_iq_scheduler #(
    parameter int DSZ = 16,
    parameter int PSZ = 11,
    parameter int ASZ = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [DSZ-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic        [ASZ-1:0] fcw_data,
    input  logic                  fcw_wr,
    input  logic                  phase_clr,
    output logic                  cfg_busy,
    output logic                  mix_cos,
    output logic        [PSZ-1:0] mix_phs,
    output logic signed [DSZ-1:0] mix_in,
    input  logic signed [DSZ-1:0] mix_out,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q,
    output logic                  out_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COS  = 2'd1;
    localparam logic [1:0] ST_SIN  = 2'd2;

    localparam int DL_LEN  = 4;
    localparam int TAG_LEN = 6;

    logic [1:0]            state_q, state_d;
    logic signed [DSZ-1:0] sample_q, sample_d;
    logic [ASZ-1:0]        acc_q, acc_d;
    logic [ASZ-1:0]        fcw_act_q, fcw_act_d;
    logic [ASZ-1:0]        fcw_pend_q, fcw_pend_d;
    logic                  fcw_pv_q, fcw_pv_d;
    logic                  clr_pv_q, clr_pv_d;
    logic signed [DSZ-1:0] dl_data_q [DL_LEN];
    logic signed [DSZ-1:0] dl_data_d [DL_LEN];
    logic [DL_LEN-1:0]     dl_vld_q, dl_vld_d;
    logic [TAG_LEN-1:0]    tg_vld_q, tg_vld_d;
    logic [TAG_LEN-1:0]    tg_cos_q, tg_cos_d;
    logic signed [DSZ-1:0] out_i_q, out_i_d;
    logic signed [DSZ-1:0] out_q_q, out_q_d;
    logic                  out_valid_q, out_valid_d;

    logic accept, boundary, idle, slot;
    logic fcw_now, fcw_pend_apply, clr_apply;

    assign in_ready  = reset && ((state_q == ST_IDLE) || (state_q == ST_SIN));
    assign mix_cos   = (state_q == ST_COS);
    assign mix_phs   = acc_q[ASZ-1 -: PSZ];
    assign mix_in    = dl_vld_q[DL_LEN-1] ? dl_data_q[DL_LEN-1] : '0;
    assign cfg_busy  = fcw_pv_q | clr_pv_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        sample_d    = sample_q;
        acc_d       = acc_q;
        fcw_act_d   = fcw_act_q;
        fcw_pend_d  = fcw_pend_q;
        fcw_pv_d    = fcw_pv_q;
        clr_pv_d    = clr_pv_q;

        accept   = in_valid && in_ready;
        boundary = (state_q == ST_SIN);
        idle     = (state_q == ST_IDLE);
        slot     = (state_q == ST_COS) || (state_q == ST_SIN);

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_COS;
            ST_COS:  state_d = ST_SIN;
            ST_SIN:  state_d = accept ? ST_COS : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) sample_d = in_data;

        // A write landing on the boundary itself takes effect there; otherwise it waits.
        fcw_now        = boundary && fcw_wr;
        fcw_pend_apply = fcw_pv_q && (boundary || idle);
        clr_apply      = (boundary && phase_clr) || (clr_pv_q && (boundary || idle));

        if (fcw_wr) fcw_pend_d = fcw_data;
        if (fcw_now)             fcw_act_d = fcw_data;
        else if (fcw_pend_apply) fcw_act_d = fcw_pend_q;

        if (fcw_wr && !boundary)             fcw_pv_d = 1'b1;
        else if (fcw_now || fcw_pend_apply)  fcw_pv_d = 1'b0;

        if (phase_clr && !boundary) clr_pv_d = 1'b1;
        else if (clr_apply)         clr_pv_d = 1'b0;

        if (clr_apply)     acc_d = '0;
        else if (boundary) acc_d = acc_q + fcw_act_q;

        dl_data_d[0] = slot ? sample_q : '0;
        for (int i = 1; i < DL_LEN; i++) dl_data_d[i] = dl_data_q[i-1];
        dl_vld_d = {dl_vld_q[DL_LEN-2:0], slot};
        tg_vld_d = {tg_vld_q[TAG_LEN-2:0], slot};
        tg_cos_d = {tg_cos_q[TAG_LEN-2:0], (state_q == ST_COS)};

        out_i_d     = (tg_vld_q[TAG_LEN-1] && tg_cos_q[TAG_LEN-1]) ? mix_out : out_i_q;
        out_valid_d = tg_vld_q[TAG_LEN-1] && !tg_cos_q[TAG_LEN-1];
        out_q_d     = out_valid_d ? mix_out : out_q_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            acc_q       <= '0;
            fcw_act_q   <= '0;
            fcw_pend_q  <= '0;
            fcw_pv_q    <= 1'b0;
            clr_pv_q    <= 1'b0;
            // NOTE: the delay-line storage is cleared too, so nothing in flight survives a reset.
            for (int i = 0; i < DL_LEN; i++) dl_data_q[i] <= '0;
            dl_vld_q    <= '0;
            tg_vld_q    <= '0;
            tg_cos_q    <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            acc_q       <= acc_d;
            fcw_act_q   <= fcw_act_d;
            fcw_pend_q  <= fcw_pend_d;
            fcw_pv_q    <= fcw_pv_d;
            clr_pv_q    <= clr_pv_d;
            for (int i = 0; i < DL_LEN; i++) dl_data_q[i] <= dl_data_d[i];
            dl_vld_q    <= dl_vld_d;
            tg_vld_q    <= tg_vld_d;
            tg_cos_q    <= tg_cos_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
